// File: rtl/spectrum_ram_reader_pkg.sv
// Shared definitions for the spectrum RAM read side: scan FSM encoding and
// the default bin window. Also consumed by modulation_detect.
package spectrum_ram_reader_pkg;

    // Scan controller states, 3-bit encoding shared with downstream logic.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN1  = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_SCAN2  = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_FINISH = 3'd5
    } scan_state_e;

    // Default bin window: skip DC, cover the lower half of a 4096-point spectrum.
    localparam int DEF_START_BIN = 1;
    localparam int DEF_END_BIN   = 2047;

    // Number of bins visited per pass.
    localparam int BIN_COUNT = DEF_END_BIN - DEF_START_BIN + 1;

endpackage

// File: rtl/spectrum_ram_reader_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a third flop
// that turns its rising edge into a single-cycle strobe in the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus edge-history flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/spectrum_ram_reader.sv
// Two-pass scanner over the FFT magnitude RAM: pass 1 finds the peak bin,
// pass 2 counts bins at or above peak >> THR_SHIFT. Results are held between
// scans and announced with a one-cycle done pulse.
module spectrum_ram_reader
    import spectrum_ram_reader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int START_BIN = DEF_START_BIN,
    parameter int END_BIN   = DEF_END_BIN,
    parameter int THR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] peak_addr,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W:0]   above_cnt,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] L_START   = ADDR_W'(START_BIN);
    localparam logic [ADDR_W-1:0] L_END     = ADDR_W'(END_BIN);
    localparam logic [1:0]        L_DRN_END = 2'(RD_LAT - 1);

    scan_state_e r_state;
    scan_state_e w_state_nxt;

    logic              w_start;
    logic [1:0]        r_drain;
    logic              w_drain_last;
    logic              w_issue;

    // Read-latency delay line: valid flag and address of each outstanding read.
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [ADDR_W-1:0] r_addr_pipe [RD_LAT];
    logic              w_samp_vld;
    logic [ADDR_W-1:0] w_samp_addr;

    // Working results.
    logic [DATA_W-1:0] r_max;
    logic [ADDR_W-1:0] r_max_addr;
    logic [DATA_W-1:0] r_thr;
    logic [ADDR_W:0]   r_cnt;
    logic              w_pk_upd;
    logic [DATA_W-1:0] w_max_nxt;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (wr_done),
        .o_rise  (w_start)
    );

    assign w_issue      = (r_state == ST_SCAN1) || (r_state == ST_SCAN2);
    assign w_drain_last = (r_drain == L_DRN_END);
    assign w_samp_vld   = r_vld_pipe[RD_LAT-1];
    assign w_samp_addr  = r_addr_pipe[RD_LAT-1];

    // Strictly-greater compare keeps the lowest address on ties.
    assign w_pk_upd  = w_samp_vld && (rd_data > r_max);
    assign w_max_nxt = w_pk_upd ? rd_data : r_max;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; start events outside IDLE are dropped.
    // NOTE: the default assignment at the top keeps this block free of latches
    // whichever case arm is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start)          w_state_nxt = ST_SCAN1;
            ST_SCAN1:  if (rd_addr == L_END) w_state_nxt = ST_DRAIN1;
            ST_DRAIN1: if (w_drain_last)     w_state_nxt = ST_SCAN2;
            ST_SCAN2:  if (rd_addr == L_END) w_state_nxt = ST_DRAIN2;
            ST_DRAIN2: if (w_drain_last)     w_state_nxt = ST_FINISH;
            ST_FINISH:                       w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Delay line tagging each RAM return with its valid flag and bin address.
    // NOTE: these few pipeline flops are reset so a scan aborted by rst cannot
    // leave a stale valid sample behind; the RAM itself is external.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) r_addr_pipe[i] <= '0;
        end else begin
            r_vld_pipe[0]  <= w_issue;
            r_addr_pipe[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end
        end
    end

    // Address generation, peak search, threshold count and result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            peak_addr  <= '0;
            peak_mag   <= '0;
            above_cnt  <= '0;
            frame_cnt  <= '0;
            r_drain    <= '0;
            r_max      <= '0;
            r_max_addr <= '0;
            r_thr      <= '0;
            r_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_max      <= '0;
                    r_max_addr <= L_START;
                    r_cnt      <= '0;
                    if (w_start) begin
                        rd_addr <= L_START;
                        busy    <= 1'b1;
                    end
                end
                ST_SCAN1: begin
                    r_drain <= '0;
                    if (rd_addr != L_END) rd_addr <= rd_addr + ADDR_W'(1);
                    if (w_pk_upd) begin
                        r_max      <= rd_data;
                        r_max_addr <= w_samp_addr;
                    end
                end
                ST_DRAIN1: begin
                    r_drain <= r_drain + 2'd1;
                    if (w_pk_upd) begin
                        r_max      <= rd_data;
                        r_max_addr <= w_samp_addr;
                    end
                    // Final write before SCAN2 sees the last pass-1 sample.
                    r_thr <= w_max_nxt >> THR_SHIFT;
                    if (w_drain_last) rd_addr <= L_START;
                end
                ST_SCAN2: begin
                    r_drain <= '0;
                    if (rd_addr != L_END) rd_addr <= rd_addr + ADDR_W'(1);
                    if (w_samp_vld && (rd_data >= r_thr)) r_cnt <= r_cnt + (ADDR_W+1)'(1);
                end
                ST_DRAIN2: begin
                    r_drain <= r_drain + 2'd1;
                    if (w_samp_vld && (rd_data >= r_thr)) r_cnt <= r_cnt + (ADDR_W+1)'(1);
                end
                ST_FINISH: begin
                    peak_addr <= r_max_addr;
                    peak_mag  <= r_max;
                    above_cnt <= r_cnt;
                    frame_cnt <= frame_cnt + 8'd1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_ram_reader.sv
// Directed bench: two scanners (RD_LAT=1 and RD_LAT=2) share stimulus and one
// magnitude RAM image; each has its own RAM read pipeline of matching latency.
// Latency is counted inclusively from the first cycle busy is high to the
// cycle done is high: 2*(N+RD_LAT)+2.
module tb_spectrum_ram_reader;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int LAT_A = 2 * (2047 + 1) + 2;  // 4098
    localparam int LAT_B = 2 * (2047 + 2) + 2;  // 4100

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_done;

    logic [AW-1:0] rd_addr_a, rd_addr_b, peak_addr_a, peak_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b, peak_mag_a, peak_mag_b, ram_b_s1;
    logic          busy_a, busy_b, done_a, done_b;
    logic [AW:0]   above_a, above_b;
    logic [7:0]    frame_a, frame_b;

    logic [DW-1:0] mem [4096];

    int tests = 0;
    int fails = 0;

    int n_done_a, n_done_b, lat_a, lat_b, cnt_a, cnt_b;
    bit started_a, started_b;

    always #5 clk = ~clk;

    spectrum_ram_reader #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .wr_done(wr_done),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a),
        .peak_addr(peak_addr_a), .peak_mag(peak_mag_a),
        .above_cnt(above_a), .frame_cnt(frame_a)
    );

    spectrum_ram_reader #(.RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .wr_done(wr_done),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b),
        .peak_addr(peak_addr_b), .peak_mag(peak_mag_b),
        .above_cnt(above_b), .frame_cnt(frame_b)
    );

    // Synchronous RAM read ports with 1 and 2 cycles of latency.
    always @(posedge clk) begin
        rd_data_a <= mem[rd_addr_a];
        ram_b_s1  <= mem[rd_addr_b];
        rd_data_b <= ram_b_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < 4096; i++) mem[i] = v;
    endtask

    // Raise wr_done for `hold` cycles (again at `retrig` if nonzero) and watch
    // both DUTs for `total` cycles, recording done pulses and latency.
    task automatic run_scan(input int hold, input int retrig, input int total);
        n_done_a = 0; n_done_b = 0; lat_a = 0; lat_b = 0;
        cnt_a = 0; cnt_b = 0; started_a = 0; started_b = 0;
        wr_done = 1'b1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (busy_a && !started_a) started_a = 1;
            if (busy_b && !started_b) started_b = 1;
            if (started_a) cnt_a++;
            if (started_b) cnt_b++;
            if (done_a) begin n_done_a++; if (n_done_a == 1) lat_a = cnt_a; end
            if (done_b) begin n_done_b++; if (n_done_b == 1) lat_b = cnt_b; end
            if (c == hold) wr_done = 1'b0;
            if (retrig > 0 && c == retrig) wr_done = 1'b1;
            if (retrig > 0 && c == retrig + hold) wr_done = 1'b0;
        end
        wr_done = 1'b0;
    endtask

    task automatic check_results(input string tag, input int pa, input int pm,
                                 input int ac, input int fc);
        check({tag, " A peak_addr"}, 32'(peak_addr_a), pa);
        check({tag, " A peak_mag"},  32'(peak_mag_a),  pm);
        check({tag, " A above_cnt"}, 32'(above_a),     ac);
        check({tag, " A frame_cnt"}, 32'(frame_a),     fc);
        check({tag, " A done pulses"}, n_done_a, 1);
        check({tag, " A latency"},   lat_a, LAT_A);
        check({tag, " B peak_addr"}, 32'(peak_addr_b), pa);
        check({tag, " B peak_mag"},  32'(peak_mag_b),  pm);
        check({tag, " B above_cnt"}, 32'(above_b),     ac);
        check({tag, " B frame_cnt"}, 32'(frame_b),     fc);
        check({tag, " B done pulses"}, n_done_b, 1);
        check({tag, " B latency"},   lat_b, LAT_B);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " A rd_addr"},   32'(rd_addr_a),   0);
        check({tag, " A busy"},      32'(busy_a),      0);
        check({tag, " A done"},      32'(done_a),      0);
        check({tag, " A peak_addr"}, 32'(peak_addr_a), 0);
        check({tag, " A peak_mag"},  32'(peak_mag_a),  0);
        check({tag, " A above_cnt"}, 32'(above_a),     0);
        check({tag, " A frame_cnt"}, 32'(frame_a),     0);
        check({tag, " B rd_addr"},   32'(rd_addr_b),   0);
        check({tag, " B busy"},      32'(busy_b),      0);
        check({tag, " B peak_mag"},  32'(peak_mag_b),  0);
        check({tag, " B frame_cnt"}, 32'(frame_b),     0);
    endtask

    initial begin
        rst = 1'b1;
        wr_done = 1'b0;
        fill(16'h0000);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single peak at bin 100; threshold 0x0200 excludes the 0x0010 floor.
        fill(16'h0010);
        mem[100] = 16'h0800;
        run_scan(4, 0, 4300);
        check_results("peak100", 100, 16'h0800, 1, 1);

        // Tie at 300/700: lower address wins; retrigger 500 cycles in is ignored.
        fill(16'h0000);
        mem[300] = 16'h1234;
        mem[700] = 16'h1234;
        run_scan(4, 500, 4300);
        check_results("tie_retrig", 300, 16'h1234, 2, 2);

        // All-zero window with wr_done held high: one scan, threshold 0 counts all.
        fill(16'h0000);
        run_scan(10000, 0, 10100);
        check_results("zero_held", 1, 0, 2047, 3);

        // Bins 0 and 2048 lie outside the window.
        fill(16'h0001);
        mem[0]    = 16'hFFFF;
        mem[2047] = 16'h0400;
        mem[2048] = 16'hFFFF;
        run_scan(4, 0, 4300);
        check_results("bounds", 2047, 16'h0400, 1, 4);

        // Reset 1000 cycles into a scan: outputs clear immediately.
        fill(16'h0010);
        mem[100] = 16'h0800;
        wr_done = 1'b1;
        repeat (4) @(negedge clk);
        wr_done = 1'b0;
        cnt_a = 0;
        while (!busy_a && cnt_a < 20) begin
            @(negedge clk);
            cnt_a++;
        end
        check("midrst A busy before abort", 32'(busy_a), 1);
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_scan(4, 0, 4300);
        check_results("after_rst", 100, 16'h0800, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
